druaga_spram: RTL and testbench

- Sprite attribute RAM on the responder side of the renderer's SPRA_A/SPRA_D interface.
- The CPU writes sprite attributes (code/colour, Y/X, size/flip) into three 8-bit working lanes.
- At the start of vertical blank, an FSM snapshots all 128 working entries into a 128x24 display buffer.
- The sprite renderer reads only the display buffer, so CPU writes never tear a frame.

---
 rtl/druaga_spram.sv | 151 +++++++++++++++
 tb/tb_druaga_spram.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/druaga_spram.sv
// Sprite attribute RAM: three CPU-written working lanes snapshotted into a display
// buffer at each VBLK rise. Optional CPU read-back: define DRUAGA_SPRAM_CPU_READ_EN.
`timescale 1ns/1ps

module druaga_spram #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 8
) (
    input  logic            VCLKx8,
    input  logic            RESET_N,
    input  logic            VBLK,
    input  logic            CPU_WE,
    input  logic [1:0]      CPU_LANE,
    input  logic [AW-1:0]   CPU_AD,
    input  logic [DW-1:0]   CPU_DI,
    output logic [DW-1:0]   CPU_DO,
    input  logic [AW-1:0]   SPRA_A,
    output logic [3*DW-1:0] SPRA_D,
    output logic            COPY_BUSY
);

    localparam int unsigned DEPTH    = 1 << AW;
    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_LAST
    } state_t;

    state_t             state_q, state_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic               vblk_d_q;
    logic               start;

    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [3*DW-1:0]    rd_data_q;
    logic               wr_en_q;
    logic [AW-1:0]      wr_addr_q;
    logic [3*DW-1:0]    spra_d_q;

    logic [DW-1:0]      lane0_mem [DEPTH];
    logic [DW-1:0]      lane1_mem [DEPTH];
    logic [DW-1:0]      lane2_mem [DEPTH];
    logic [3*DW-1:0]    disp_mem  [DEPTH];

    // vblk_d resets high so a reset released inside VBLK cannot look like a rising edge
    assign start = VBLK & ~vblk_d_q;

    always_ff @(posedge VCLKx8 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            vblk_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vblk_d_q <= VBLK;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RD;
                    cnt_d   = '0;
                end
            end
            ST_RD: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_LAST;
                end
            end
            ST_LAST: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        COPY_BUSY = (state_q != ST_IDLE);
        rd_en     = (state_q == ST_RD);
        rd_addr   = cnt_q[AW-1:0];
    end

    // Working lanes: CPU write port plus copy-engine read (old data wins on collision)
    always_ff @(posedge VCLKx8) begin
        if (CPU_WE) begin
            case (CPU_LANE)
                2'd0:    lane0_mem[CPU_AD] <= CPU_DI;
                2'd1:    lane1_mem[CPU_AD] <= CPU_DI;
                2'd2:    lane2_mem[CPU_AD] <= CPU_DI;
                default: ;
            endcase
        end
        if (rd_en) begin
            rd_data_q <= {lane2_mem[rd_addr], lane1_mem[rd_addr], lane0_mem[rd_addr]};
        end
        if (wr_en_q) begin
            disp_mem[wr_addr_q] <= rd_data_q;
        end
    end

    // Display write trails the working read by one cycle, covering cnt-1 each cycle
    always_ff @(posedge VCLKx8 or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            spra_d_q  <= '0;
        end else begin
            wr_en_q   <= rd_en;
            wr_addr_q <= rd_addr;
            spra_d_q  <= disp_mem[SPRA_A];
        end
    end

    assign SPRA_D = spra_d_q;

`ifdef DRUAGA_SPRAM_CPU_READ_EN
    logic [DW-1:0] cpu_do_q;

    always_ff @(posedge VCLKx8 or negedge RESET_N) begin
        if (!RESET_N) begin
            cpu_do_q <= '0;
        end else begin
            case (CPU_LANE)
                2'd0:    cpu_do_q <= lane0_mem[CPU_AD];
                2'd1:    cpu_do_q <= lane1_mem[CPU_AD];
                2'd2:    cpu_do_q <= lane2_mem[CPU_AD];
                default: cpu_do_q <= '0;
            endcase
        end
    end

    assign CPU_DO = cpu_do_q;
`else
    assign CPU_DO = '0;
`endif

endmodule

// File: tb/tb_druaga_spram.sv
// Scoreboard bench for druaga_spram: working/display models, renderer reads queued
// with their expected value and compared when the registered SPRA_D appears.
`timescale 1ns/1ps

module tb_druaga_spram;

    logic        clk;
    logic        rst_n;
    logic        vblk;
    logic        cpu_we;
    logic [1:0]  cpu_lane;
    logic [6:0]  cpu_ad;
    logic [7:0]  cpu_di;
    logic [7:0]  cpu_do;
    logic [6:0]  spra_a;
    logic [23:0] spra_d;
    logic        copy_busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  wmem [3][128];
    logic [23:0] dmem [128];
    logic [31:0] exp_q [$];

    druaga_spram #(.AW(7), .DW(8)) dut (
        .VCLKx8    (clk),
        .RESET_N   (rst_n),
        .VBLK      (vblk),
        .CPU_WE    (cpu_we),
        .CPU_LANE  (cpu_lane),
        .CPU_AD    (cpu_ad),
        .CPU_DI    (cpu_di),
        .CPU_DO    (cpu_do),
        .SPRA_A    (spra_a),
        .SPRA_D    (spra_d),
        .COPY_BUSY (copy_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [1:0] l, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_we   = 1'b1;
        cpu_lane = l;
        cpu_ad   = a;
        cpu_di   = d;
        wmem[l][a] = d;
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    task automatic spra_read(input logic [6:0] a, input logic [23:0] exp, input string tag);
        logic [31:0] e;
        @(negedge clk);
        spra_a = a;
        exp_q.push_back({8'h00, exp});
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, {8'h00, spra_d}, e);
        end
    endtask

    task automatic watch_idle(input int ncyc, input string tag);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            if (copy_busy) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd0);
    endtask

    // Raises VBLK and follows the copy; optional CPU write, VBLK glitch or reset
    // at a given busy cycle (busy cycle c has the copy reading entry c-1).
    task automatic run_copy(input int inj_at, input int glitch_at, input int rst_at,
                            input logic [1:0] il, input logic [6:0] ia, input logic [7:0] id);
        logic [23:0] pre [128];
        int  c;
        logic aborted;
        for (int i = 0; i < 128; i++) pre[i] = {wmem[2][i], wmem[1][i], wmem[0][i]};
        c = 0;
        aborted = 1'b0;
        @(negedge clk);
        vblk = 1'b1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            cpu_we = 1'b0;
            if (copy_busy) c++;
            else if (c > 0) break;
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy_drop", {31'd0, copy_busy}, 32'd0);
                check("rst_spra_zero", {8'h00, spra_d}, 32'd0);
                aborted = 1'b1;
                break;
            end
            if (c == inj_at) begin
                cpu_we   = 1'b1;
                cpu_lane = il;
                cpu_ad   = ia;
                cpu_di   = id;
                wmem[il][ia] = id;
            end
            if (c == glitch_at)     vblk = 1'b0;
            if (c == glitch_at + 1) vblk = 1'b1;
        end
        cpu_we = 1'b0;
        if (!aborted) begin
            check("busy_len", c, 32'd129);
            for (int i = 0; i < 128; i++) dmem[i] = pre[i];
        end else begin
            for (int i = 0; i < rst_at - 2; i++) dmem[i] = pre[i];
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        vblk     = 1'b1;
        cpu_we   = 1'b0;
        cpu_lane = 2'd0;
        cpu_ad   = '0;
        cpu_di   = '0;
        spra_a   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, copy_busy}, 32'd0);
        check("reset_spra", {8'h00, spra_d}, 32'd0);
        check("reset_cpu_do", {24'd0, cpu_do}, 32'd0);

        // Reset released inside VBLK: no copy may start
        rst_n = 1'b1;
        watch_idle(10, "no_copy_in_vblk");
        check("spra_after_rel", {8'h00, spra_d}, 32'd0);
        vblk = 1'b0;

        for (int l = 0; l < 3; l++)
            for (int i = 0; i < 128; i++)
                cpu_write(2'(l), 7'(i), 8'(i * 7 + l * 61 + 3));
        cpu_write(2'd0, 7'd5, 8'h12);
        cpu_write(2'd1, 7'd5, 8'h34);
        cpu_write(2'd2, 7'd5, 8'h56);
        cpu_write(2'd0, 7'd127, 8'hAA);
        cpu_write(2'd1, 7'd127, 8'hBB);
        cpu_write(2'd2, 7'd127, 8'hCC);
        cpu_write(2'd1, 7'd40, 8'h00);

        // Full snapshot
        run_copy(0, 0, 0, 2'd0, 7'd0, 8'd0);
        spra_read(7'd5,   24'h563412, "snap_e5");
        spra_read(7'd127, 24'hCCBBAA, "snap_e127");
        spra_read(7'd0,   dmem[0],   "snap_e0");
        spra_read(7'd77,  dmem[77],  "snap_e77");
        @(negedge clk);
        vblk = 1'b0;

        // Frame isolation
        cpu_write(2'd0, 7'd5, 8'hFF);
        spra_read(7'd5, 24'h563412, "iso_before");

        // Collision: CPU writes entry 40 lane1 while the copy reads it
        run_copy(41, 0, 0, 2'd1, 7'd40, 8'h77);
        spra_read(7'd5, 24'h5634FF, "iso_after");
        spra_read(7'd40, {wmem[2][40], 8'h00, wmem[0][40]}, "coll_old");
        @(negedge clk);
        vblk = 1'b0;

        // VBLK re-rise mid-copy is ignored
        run_copy(0, 60, 0, 2'd0, 7'd0, 8'd0);
        spra_read(7'd40, {wmem[2][40], 8'h77, wmem[0][40]}, "coll_new");
        @(negedge clk);
        vblk = 1'b0;

        // Reset mid-copy leaves the tail of the display buffer untouched
        cpu_write(2'd2, 7'd10,  8'hE1);
        cpu_write(2'd2, 7'd60,  8'hE2);
        cpu_write(2'd2, 7'd100, 8'hE3);
        cpu_write(2'd2, 7'd127, 8'hE4);
        run_copy(0, 0, 60, 2'd0, 7'd0, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        watch_idle(8, "no_copy_after_rst");
        spra_read(7'd10,  {8'hE1, wmem[1][10], wmem[0][10]}, "part_e10");
        spra_read(7'd60,  dmem[60],  "part_e60");
        spra_read(7'd127, 24'hCCBBAA, "part_e127");
        spra_read(7'd100, dmem[100], "part_e100");
        @(negedge clk);
        vblk = 1'b0;

        run_copy(0, 0, 0, 2'd0, 7'd0, 8'd0);
        spra_read(7'd127, 24'hE4BBAA, "recov_e127");
        spra_read(7'd60,  {8'hE2, wmem[1][60], wmem[0][60]}, "recov_e60");
        @(negedge clk);
        vblk = 1'b0;

`ifdef DRUAGA_SPRAM_CPU_READ_EN
        cpu_write(2'd2, 7'd3, 8'h5A);
        @(negedge clk);
        cpu_lane = 2'd2;
        cpu_ad   = 7'd3;
        @(negedge clk);
        check("cpu_rd", {24'd0, cpu_do}, 32'h5A);
        cpu_we = 1'b1;
        cpu_di = 8'hA5;
        @(negedge clk);
        cpu_we = 1'b0;
        check("cpu_rd_old", {24'd0, cpu_do}, 32'h5A);
        @(negedge clk);
        check("cpu_rd_new", {24'd0, cpu_do}, 32'hA5);
        cpu_lane = 2'd3;
        @(negedge clk);
        check("cpu_rd_lane3", {24'd0, cpu_do}, 32'd0);
`else
        cpu_write(2'd2, 7'd3, 8'h5A);
        @(negedge clk);
        cpu_lane = 2'd2;
        cpu_ad   = 7'd3;
        @(negedge clk);
        check("cpu_do_tied", {24'd0, cpu_do}, 32'd0);
`endif

        check("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
